// File: rtl/riscv_ctrl_pipe.sv
// Registered instruction decode controller with a 2-entry skid buffer and a
// hold stage that paces RV32M ops to the iterative mul/div unit.
module riscv_ctrl_pipe #(
  parameter int unsigned EN_M          = 1,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [2:0]  o_ctrl_src_imm,
  output logic [1:0]  o_ctrl_src_rd,
  output logic        o_ctrl_src_alu_a,
  output logic        o_ctrl_src_alu_b,
  output logic        o_ctrl_reg_wr_en,
  output logic        o_ctrl_mem_wr_en,
  output logic [3:0]  o_ctrl_alu_ctrl,
  output logic        o_ctrl_muldiv,
  output logic        o_ctrl_illegal,
  output logic [4:0]  o_ctrl_rd
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RD_ALU = 2'd0;
  localparam logic [1:0] RD_MEM = 2'd1;
  localparam logic [1:0] RD_PC4 = 2'd2;
  localparam logic [1:0] RD_IMM = 2'd3;

  localparam logic ALU_A_REG = 1'b0;
  localparam logic ALU_A_PC  = 1'b1;
  localparam logic ALU_B_REG = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  // ALU op codes are {alt, funct3}: ADD=0 .. AND=7, SUB=8, SRA=13, NOP=15.
  localparam logic [3:0] ALU_CTRL_ADD = 4'd0;
  localparam logic [3:0] ALU_CTRL_NOP = 4'd15;

  localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 1);
  localparam logic       MD_HOLD  = (MULDIV_CYCLES > 1);

  typedef struct packed {
    logic [2:0] src_imm;
    logic [1:0] src_rd;
    logic       src_alu_a;
    logic       src_alu_b;
    logic       reg_wr_en;
    logic       mem_wr_en;
    logic [3:0] alu_ctrl;
    logic       muldiv;
    logic       illegal;
    logic [4:0] rd;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ONE    = 2'd1,
    S_TWO    = 2'd2,
    S_MDWAIT = 2'd3
  } state_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal_d;
  ctrl_t      dec_d;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];

  logic unused_instr_bits;
  assign unused_instr_bits = ^i_instr[24:15];

  always_comb begin
    dec_d          = '0;
    dec_d.rd       = i_instr[11:7];
    dec_d.alu_ctrl = ALU_CTRL_ADD;
    illegal_d      = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_d.src_imm   = IMM_U;
        dec_d.src_rd    = RD_IMM;
        dec_d.src_alu_b = ALU_B_IMM;
        dec_d.reg_wr_en = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.src_imm   = IMM_U;
        dec_d.src_rd    = RD_ALU;
        dec_d.src_alu_a = ALU_A_PC;
        dec_d.src_alu_b = ALU_B_IMM;
        dec_d.reg_wr_en = 1'b1;
      end
      OPC_JAL: begin
        dec_d.src_imm   = IMM_J;
        dec_d.src_rd    = RD_PC4;
        dec_d.src_alu_a = ALU_A_PC;
        dec_d.src_alu_b = ALU_B_IMM;
        dec_d.reg_wr_en = 1'b1;
      end
      OPC_JALR: begin
        dec_d.src_imm   = IMM_I;
        dec_d.src_rd    = RD_PC4;
        dec_d.src_alu_a = ALU_A_REG;
        dec_d.src_alu_b = ALU_B_IMM;
        dec_d.reg_wr_en = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.src_imm   = IMM_B;
        dec_d.src_alu_a = ALU_A_PC;
        dec_d.src_alu_b = ALU_B_IMM;
      end
      OPC_LOAD: begin
        dec_d.src_imm   = IMM_I;
        dec_d.src_rd    = RD_MEM;
        dec_d.src_alu_b = ALU_B_IMM;
        dec_d.reg_wr_en = 1'b1;
      end
      OPC_STORE: begin
        dec_d.src_imm   = IMM_S;
        dec_d.src_alu_b = ALU_B_IMM;
        dec_d.mem_wr_en = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_d.src_imm   = IMM_I;
        dec_d.src_alu_b = ALU_B_IMM;
        dec_d.reg_wr_en = 1'b1;
        // Only the shift-right immediate reuses funct7[5] (SRAI); elsewhere it is immediate data.
        dec_d.alu_ctrl  = {(funct3 == F3_SRL_SRA) & funct7[5], funct3};
      end
      OPC_OP: begin
        dec_d.src_alu_b = ALU_B_REG;
        dec_d.reg_wr_en = 1'b1;
        if (funct7 == F7_BASE) begin
          dec_d.alu_ctrl = {1'b0, funct3};
        end else if (funct7 == F7_ALT &&
                     (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)) begin
          dec_d.alu_ctrl = {1'b1, funct3};
        end else if (funct7 == F7_MULDIV && EN_M != 0) begin
          dec_d.muldiv   = 1'b1;
          dec_d.alu_ctrl = {1'b0, funct3};
        end else begin
          illegal_d = 1'b1;
        end
      end
      default: illegal_d = 1'b1;
    endcase
    if (illegal_d) begin
      dec_d.illegal   = 1'b1;
      dec_d.reg_wr_en = 1'b0;
      dec_d.mem_wr_en = 1'b0;
      dec_d.alu_ctrl  = ALU_CTRL_NOP;
      dec_d.muldiv    = 1'b0;
    end
  end

  state_t     state_q;
  ctrl_t      main_q;
  ctrl_t      skid_q;
  logic       main_vld_q;
  logic       ready_q;
  logic [7:0] cnt_q;

  logic accept;
  logic leave;
  logic acc_m;

  assign accept = i_valid && ready_q;
  assign leave  = main_vld_q && i_ready;
  // With a one-cycle hold an M op needs no pacing and takes the ordinary path.
  assign acc_m  = MD_HOLD && dec_d.muldiv;

  // The skid register holds either the second queued bundle (TWO) or the
  // pending M op (MDWAIT); main only reloads when empty or leaving.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      cnt_q      <= '0;
    end else if (i_flush) begin
      state_q    <= S_IDLE;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && acc_m) begin
            skid_q  <= dec_d;
            cnt_q   <= CNT_LOAD;
            ready_q <= 1'b0;
            state_q <= S_MDWAIT;
          end else if (accept) begin
            main_q     <= dec_d;
            main_vld_q <= 1'b1;
            state_q    <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && acc_m) begin
            skid_q  <= dec_d;
            cnt_q   <= CNT_LOAD;
            ready_q <= 1'b0;
            state_q <= S_MDWAIT;
            if (leave) main_vld_q <= 1'b0;
          end else if (accept && leave) begin
            main_q <= dec_d;
          end else if (accept) begin
            skid_q  <= dec_d;
            ready_q <= 1'b0;
            state_q <= S_TWO;
          end else if (leave) begin
            main_vld_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_TWO: begin
          if (leave) begin
            main_q  <= skid_q;
            ready_q <= 1'b1;
            state_q <= S_ONE;
          end
        end
        S_MDWAIT: begin
          if (leave) main_vld_q <= 1'b0;
          if (cnt_q > 8'd1) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            cnt_q <= '0;
            if (!main_vld_q || leave) begin
              main_q     <= skid_q;
              main_vld_q <= 1'b1;
              ready_q    <= 1'b1;
              state_q    <= S_ONE;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          main_vld_q <= 1'b0;
          ready_q    <= 1'b1;
          cnt_q      <= '0;
        end
      endcase
    end
  end

  assign o_valid          = main_vld_q;
  assign o_ready          = ready_q;
  assign o_ctrl_src_imm   = main_q.src_imm;
  assign o_ctrl_src_rd    = main_q.src_rd;
  assign o_ctrl_src_alu_a = main_q.src_alu_a;
  assign o_ctrl_src_alu_b = main_q.src_alu_b;
  assign o_ctrl_reg_wr_en = main_q.reg_wr_en;
  assign o_ctrl_mem_wr_en = main_q.mem_wr_en;
  assign o_ctrl_alu_ctrl  = main_q.alu_ctrl;
  assign o_ctrl_muldiv    = main_q.muldiv;
  assign o_ctrl_illegal   = main_q.illegal;
  assign o_ctrl_rd        = main_q.rd;

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
// Bench for riscv_ctrl_pipe: directed cases plus a random soak against an
// in-order queue model with its own instruction decode table.
module tb_riscv_ctrl_pipe;

  localparam int MDC = 4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd8;
  localparam logic [3:0] ALU_NOP = 4'd15;

  logic        clk = 1'b0;
  logic        rstn;
  logic        drv_valid, drv_ready, drv_flush;
  logic [31:0] drv_instr;

  logic d_ready, d_valid, d_a, d_b, d_wr, d_mw, d_md, d_ill;
  logic [2:0] d_imm;
  logic [1:0] d_rds;
  logic [3:0] d_alu;
  logic [4:0] d_rd;
  logic n_ready, n_valid, n_a, n_b, n_wr, n_mw, n_md, n_ill;
  logic [2:0] n_imm;
  logic [1:0] n_rds;
  logic [3:0] n_alu;
  logic [4:0] n_rd;
  logic [19:0] d_bundle, n_bundle;

  assign d_bundle = {d_imm, d_rds, d_a, d_b, d_wr, d_mw, d_alu, d_md, d_ill, d_rd};
  assign n_bundle = {n_imm, n_rds, n_a, n_b, n_wr, n_mw, n_alu, n_md, n_ill, n_rd};

  always #5 clk = ~clk;

  riscv_ctrl_pipe #(.EN_M(1), .MULDIV_CYCLES(MDC)) u_dut (
    .i_clk(clk), .i_rstn(rstn), .i_flush(drv_flush), .i_valid(drv_valid),
    .o_ready(d_ready), .i_instr(drv_instr), .o_valid(d_valid), .i_ready(drv_ready),
    .o_ctrl_src_imm(d_imm), .o_ctrl_src_rd(d_rds), .o_ctrl_src_alu_a(d_a),
    .o_ctrl_src_alu_b(d_b), .o_ctrl_reg_wr_en(d_wr), .o_ctrl_mem_wr_en(d_mw),
    .o_ctrl_alu_ctrl(d_alu), .o_ctrl_muldiv(d_md), .o_ctrl_illegal(d_ill),
    .o_ctrl_rd(d_rd)
  );

  riscv_ctrl_pipe #(.EN_M(0), .MULDIV_CYCLES(MDC)) u_dut_nom (
    .i_clk(clk), .i_rstn(rstn), .i_flush(drv_flush), .i_valid(drv_valid),
    .o_ready(n_ready), .i_instr(drv_instr), .o_valid(n_valid), .i_ready(1'b1),
    .o_ctrl_src_imm(n_imm), .o_ctrl_src_rd(n_rds), .o_ctrl_src_alu_a(n_a),
    .o_ctrl_src_alu_b(n_b), .o_ctrl_reg_wr_en(n_wr), .o_ctrl_mem_wr_en(n_mw),
    .o_ctrl_alu_ctrl(n_alu), .o_ctrl_muldiv(n_md), .o_ctrl_illegal(n_ill),
    .o_ctrl_rd(n_rd)
  );

  typedef struct {
    logic [19:0] b;
    int          acc;
    bit          seen;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Control bundle packed as {imm, rd_src, alu_a, alu_b, wr, mem_wr, alu, muldiv, illegal, rd}.
  function automatic logic [19:0] ref_decode(input logic [31:0] w, input bit en_m);
    logic [2:0] imm, f3;
    logic [1:0] rds;
    logic [6:0] f7;
    logic       a, b, wr, mw, md, ill;
    logic [3:0] alu;
    f3 = w[14:12];
    f7 = w[31:25];
    imm = 3'd0; rds = 2'd0; a = 0; b = 0; wr = 0; mw = 0; md = 0; ill = 0;
    alu = ALU_ADD;
    case (w[6:0])
      7'h37: begin imm = 3'd3; rds = 2'd3; b = 1; wr = 1; end
      7'h17: begin imm = 3'd3; a = 1; b = 1; wr = 1; end
      7'h6F: begin imm = 3'd4; rds = 2'd2; a = 1; b = 1; wr = 1; end
      7'h67: begin imm = 3'd0; rds = 2'd2; b = 1; wr = 1; end
      7'h63: begin imm = 3'd2; a = 1; b = 1; end
      7'h03: begin imm = 3'd0; rds = 2'd1; b = 1; wr = 1; end
      7'h23: begin imm = 3'd1; b = 1; mw = 1; end
      7'h13: begin
        b = 1; wr = 1;
        alu = 4'(f3);
        if (f3 == 3'd5 && f7[5]) alu = 4'(f3) + 4'd8;
      end
      7'h33: begin
        wr = 1;
        if (f7 == 7'h00) alu = 4'(f3);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) alu = 4'(f3) + 4'd8;
        else if (f7 == 7'h01 && en_m) begin md = 1; alu = 4'(f3); end
        else ill = 1;
      end
      default: ill = 1;
    endcase
    if (ill) begin wr = 0; mw = 0; alu = ALU_NOP; md = 0; end
    return {imm, rds, a, b, wr, mw, alu, md, ill, w[11:7]};
  endfunction

  function automatic bit m_waiting();
    for (int i = 0; i < q.size(); i++)
      if (q[i].b[6] && !q[i].seen) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, compare against the queue model, then advance the model.
  task automatic step(input bit v, input logic [31:0] w, input bit rdy, input bit fl);
    bit   exp_vld, exp_rdy;
    ent_t e;
    @(negedge clk);
    drv_valid = v; drv_instr = w; drv_ready = rdy; drv_flush = fl;
    #1;
    exp_vld = 1'b0;
    if (q.size() > 0) begin
      e = q[0];
      if (!e.b[6] || e.seen || (cyc - e.acc) >= MDC) begin
        e.seen = 1'b1;
        q[0] = e;
        exp_vld = 1'b1;
      end
    end
    exp_rdy = (q.size() < 2) && !m_waiting();
    check_eq("o_valid", d_valid, exp_vld);
    check_eq("o_ready", d_ready, exp_rdy);
    if (exp_vld) check_eq("bundle", d_bundle, q[0].b);
    if (exp_vld && rdy) void'(q.pop_front());
    if (fl) q.delete();
    else if (v && exp_rdy) begin
      e.b = ref_decode(w, 1'b1); e.acc = cyc; e.seen = 1'b0;
      q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h13;
      8, 9, 10: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 4))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2, 3: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int lat, acc0, guard;
    rstn = 1'b0;
    drv_valid = 0; drv_ready = 0; drv_flush = 0; drv_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", d_valid, 0);
    check_eq("rst_ready", d_ready, 1);
    check_eq("rst_bundle", d_bundle, 0);
    @(negedge clk) rstn = 1'b1;

    // Streaming at full rate, latency 1
    step(1, 32'h003100B3, 1, 0); #1;
    check_eq("add_lat", d_valid, 1);
    check_eq("add_alu", d_alu, ALU_ADD);
    step(1, 32'h403100B3, 1, 0); #1;
    check_eq("sub_alu", d_alu, ALU_SUB);
    step(1, 32'hC0000093, 1, 0); #1;
    check_eq("addi_alu", d_alu, ALU_ADD);
    check_eq("addi_wr", d_wr, 1);
    step(0, 0, 1, 0);

    // Backpressure: o_ready drops after the second held accept
    step(1, 32'h00208133, 0, 0); #1;
    check_eq("bp_ready1", d_ready, 1);
    step(1, 32'h402081B3, 0, 0); #1;
    check_eq("bp_ready2", d_ready, 0);
    step(1, 32'h00000013, 0, 0);
    repeat (3) step(0, 0, 1, 0);

    // M op latency on EN_M=1, illegal on EN_M=0
    step(1, 32'h023100B3, 0, 0); #1;
    check_eq("nom_valid", n_valid, 1);
    check_eq("nom_ready", n_ready, 1);
    check_eq("nom_illegal", n_ill, 1);
    check_eq("nom_wr", n_wr, 0);
    check_eq("nom_bundle", n_bundle, ref_decode(32'h023100B3, 1'b0));
    lat = 1;
    while (!d_valid && lat < 20) begin
      check_eq("md_ready_low", d_ready, 0);
      step(0, 0, 0, 0); #1;
      lat++;
    end
    check_eq("md_latency", lat, MDC);
    check_eq("md_muldiv", d_md, 1);
    check_eq("md_alu", d_alu, 0);
    step(0, 0, 1, 0);

    // Illegal word and store
    step(1, 32'h00000000, 1, 0); #1;
    check_eq("ill_flag", d_ill, 1);
    check_eq("ill_memwr", d_mw, 0);
    step(1, 32'h0020A023, 1, 0); #1;
    check_eq("sw_memwr", d_mw, 1);
    check_eq("sw_regwr", d_wr, 0);
    check_eq("sw_alub", d_b, 1);
    step(0, 0, 1, 0);

    // Flush while in TWO
    step(1, 32'h00310233, 0, 0);
    step(1, 32'h003102B3, 0, 0);
    step(1, 32'h00310333, 0, 1); #1;
    check_eq("flush2_valid", d_valid, 0);
    check_eq("flush2_ready", d_ready, 1);
    repeat (3) step(0, 0, 1, 0);

    // Flush in MDWAIT with the counter at 2
    step(1, 32'h0231C0B3, 1, 0);
    step(0, 0, 1, 0);
    step(1, 32'h00310233, 1, 1); #1;
    check_eq("flushm_valid", d_valid, 0);
    check_eq("flushm_ready", d_ready, 1);
    repeat (6) step(0, 0, 1, 0);

    // Asynchronous reset in the middle of a stream
    step(1, 32'h003100B3, 1, 0);
    step(1, 32'h403100B3, 0, 0);
    @(negedge clk);
    drv_valid = 0;
    #2 rstn = 1'b0;
    #1;
    check_eq("mid_rst_valid", d_valid, 0);
    check_eq("mid_rst_ready", d_ready, 1);
    check_eq("mid_rst_bundle", d_bundle, 0);
    q.delete();
    @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // Random soak
    acc0 = n_acc;
    guard = 0;
    while ((n_acc - acc0) < 10000 && guard < 60000) begin
      step($urandom_range(0, 9) < 7, gen_instr(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 299) == 0);
      guard++;
    end
    check_eq("soak_count", ((n_acc - acc0) >= 10000), 1);
    repeat (12) step(0, 0, 1, 0);
    check_eq("soak_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
